// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory boot loader
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;
    localparam int         LEN_BYTES     = 4;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input, memory write port and status of the boot loader
interface imem_loader_if #(
    parameter int ADDR_W = 14
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              clear;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   loaded_words;

    modport slave (
        input  rx_valid, rx_data, clear,
        output rx_ready, imem_we, imem_addr, imem_wdata, core_hold, done, err, loaded_words
    );

    modport master (
        output rx_valid, rx_data, clear,
        input  rx_ready, imem_we, imem_addr, imem_wdata, core_hold, done, err, loaded_words
    );
endinterface

// File: rtl/imem_loader_word_packer.sv
// rtl/imem_loader_word_packer.sv - packs little-endian bytes into 32-bit words and keeps a running XOR
module loader_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    output logic [1:0]  lane_o,
    output logic [7:0]  csum_o
);
    logic [31:0] word_q, word_d;
    logic [1:0]  lane_q;
    logic [7:0]  csum_q;
    logic        word_valid_q;

    always_comb begin
        word_d = word_q;
        if (byte_valid_i) begin
            word_d[{lane_q, 3'b000} +: 8] = byte_i;
        end
    end

    // word_valid trails the fourth byte by one cycle, when word_q holds the full word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q       <= '0;
            lane_q       <= '0;
            csum_q       <= '0;
            word_valid_q <= 1'b0;
        end else if (start_i) begin
            lane_q       <= '0;
            csum_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= byte_valid_i && (lane_q == 2'd3);
            if (byte_valid_i) begin
                word_q <= word_d;
                lane_q <= lane_q + 2'd1;
                csum_q <= csum_q ^ byte_i;
            end
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;
    assign lane_o       = lane_q;
    assign csum_o       = csum_q;
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - receives a framed byte stream and writes it into instruction memory
module imem_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W    = 14,
    parameter int         BASE_ADDR = 0,
    parameter logic [7:0] MAGIC     = DEFAULT_MAGIC
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);
    localparam logic [32:0]       CAPACITY = 33'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    state_e            state_q, state_d;
    logic [31:0]       len_q, len_d;
    logic [1:0]        lcnt_q, lcnt_d;
    logic [ADDR_W:0]   lw_q, lw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;
    logic              pk_start, pk_valid;
    logic [1:0]        pk_lane;
    logic [7:0]        pk_csum;
    logic              rx_ready;
    logic              accept;

    assign rx_ready = (state_q != ST_ERR);
    assign accept   = bus.rx_valid && rx_ready;

    loader_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .start_i      (pk_start),
        .byte_valid_i (pk_valid),
        .byte_i       (bus.rx_data),
        .word_o       (bus.imem_wdata),
        .word_valid_o (bus.imem_we),
        .lane_o       (pk_lane),
        .csum_o       (pk_csum)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        lcnt_d   = lcnt_q;
        lw_d     = lw_q;
        addr_d   = addr_q;
        done_d   = done_q;
        err_d    = err_q;
        hold_d   = hold_q;
        pk_start = 1'b0;
        pk_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && bus.rx_data == MAGIC) begin
                    state_d  = ST_LEN;
                    hold_d   = 1'b1;
                    done_d   = 1'b0;
                    lw_d     = '0;
                    len_d    = '0;
                    lcnt_d   = '0;
                    pk_start = 1'b1;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    len_d[{lcnt_q, 3'b000} +: 8] = bus.rx_data;
                    lcnt_d = lcnt_q + 2'd1;
                    if (lcnt_q == 2'(LEN_BYTES - 1)) begin
                        if ({1'b0, len_d} > CAPACITY) begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end else if (len_d == 32'd0) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                pk_valid = accept;
                // address is latched with the fourth byte so it lines up with the packer's write pulse
                if (accept && pk_lane == 2'd3) begin
                    lw_d   = lw_q + 1'b1;
                    addr_d = BASE + lw_q[ADDR_W-1:0];
                    if (32'(lw_d) == len_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (bus.rx_data == pk_csum) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (bus.clear) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (bus.clear) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            lcnt_q  <= '0;
            lw_q    <= '0;
            addr_q  <= BASE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            lcnt_q  <= lcnt_d;
            lw_q    <= lw_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.rx_ready     = rx_ready;
    assign bus.imem_addr    = addr_q;
    assign bus.core_hold    = hold_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.loaded_words = lw_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed table-driven bench for imem_loader
module tb_imem_loader;
    localparam int ADDR_W = 14;
    localparam int BASE   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAGIC(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        clr;
        logic        we;
        logic [13:0] addr;
        logic [31:0] wd;
        logic        done;
        logic        err;
        logic        hold;
        logic        rdy;
        logic [14:0] lw;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic row(input logic v, input logic [7:0] d, input logic clr, input logic we,
                       input logic [13:0] addr, input logic [31:0] wd, input logic done,
                       input logic err, input logic hold, input logic rdy, input logic [14:0] lw);
        vec_t r;
        r.v = v; r.d = d; r.clr = clr; r.we = we; r.addr = addr; r.wd = wd;
        r.done = done; r.err = err; r.hold = hold; r.rdy = rdy; r.lw = lw;
        tbl.push_back(r);
    endtask

    // two-word frame; checksum of its data is 8'h90
    task automatic add_frame(input logic [7:0] cs, input logic good, input logic hold_before);
        logic [7:0] b [13];
        b = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < 13; i++) begin
            if (i == 8)       row(1, b[i], 0, 1, 14'd5, 32'h00000013, 0, 0, 1, 1, 15'd1);
            else if (i == 12) row(1, b[i], 0, 1, 14'd6, 32'h00100093, 0, 0, 1, 1, 15'd2);
            else              row(1, b[i], 0, 0, 0, 0, 0, 0, 1, 1, (i > 8) ? 15'd1 : 15'd0);
        end
        if (good) row(1, cs, 0, 0, 0, 0, 1, 0, 0, 1, 15'd2);
        else      row(1, cs, 0, 0, 0, 0, 0, 1, 1, 0, 15'd2);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic clr);
        @(negedge clk);
        bus.rx_valid = v;
        bus.rx_data  = d;
        bus.clear    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " rx_ready"},     32'(bus.rx_ready), 32'd1);
        chk({tag, " imem_we"},      32'(bus.imem_we), 32'd0);
        chk({tag, " imem_addr"},    32'(bus.imem_addr), 32'(BASE));
        chk({tag, " imem_wdata"},   bus.imem_wdata, 32'd0);
        chk({tag, " core_hold"},    32'(bus.core_hold), 32'd0);
        chk({tag, " done"},         32'(bus.done), 32'd0);
        chk({tag, " err"},          32'(bus.err), 32'd0);
        chk({tag, " loaded_words"}, 32'(bus.loaded_words), 32'd0);
    endtask

    initial begin
        logic [7:0] fr [14];
        logic [7:0] fr2 [10];
        int gaps;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.clear    = 1'b0;
        #12;
        chk_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // basic load, ignored bytes in DONE, clear
        add_frame(8'h90, 1, 0);
        row(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 1, 15'd2);
        row(1, 8'hA5, 0, 0, 0, 0, 1, 0, 0, 1, 15'd2);
        row(1, 8'h13, 0, 0, 0, 0, 1, 0, 0, 1, 15'd2);
        row(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 1, 15'd2);
        // bad checksum, then clear out of ERR
        add_frame(8'h91, 0, 1);
        row(1, 8'hA5, 0, 0, 0, 0, 0, 1, 1, 0, 15'd2);
        row(0, 8'h00, 1, 0, 0, 0, 0, 0, 1, 1, 15'd2);
        // zero-length frame
        row(1, 8'hA5, 0, 0, 0, 0, 0, 0, 1, 1, 15'd0);
        for (int i = 0; i < 4; i++) row(1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 15'd0);
        row(1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 1, 15'd0);
        row(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 1, 15'd0);
        // oversize length 2**14+1
        row(1, 8'hA5, 0, 0, 0, 0, 0, 0, 1, 1, 15'd0);
        row(1, 8'h01, 0, 0, 0, 0, 0, 0, 1, 1, 15'd0);
        row(1, 8'h40, 0, 0, 0, 0, 0, 0, 1, 1, 15'd0);
        row(1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 15'd0);
        row(1, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, 15'd0);
        row(1, 8'h13, 0, 0, 0, 0, 0, 1, 1, 0, 15'd0);
        row(1, 8'h13, 0, 0, 0, 0, 0, 1, 1, 0, 15'd0);
        row(0, 8'h00, 1, 0, 0, 0, 0, 0, 1, 1, 15'd0);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].clr);
            chk($sformatf("row%0d we", i),   32'(bus.imem_we), 32'(tbl[i].we));
            chk($sformatf("row%0d rdy", i),  32'(bus.rx_ready), 32'(tbl[i].rdy));
            chk($sformatf("row%0d done", i), 32'(bus.done), 32'(tbl[i].done));
            chk($sformatf("row%0d err", i),  32'(bus.err), 32'(tbl[i].err));
            chk($sformatf("row%0d hold", i), 32'(bus.core_hold), 32'(tbl[i].hold));
            chk($sformatf("row%0d lw", i),   32'(bus.loaded_words), 32'(tbl[i].lw));
            if (tbl[i].we) begin
                chk($sformatf("row%0d addr", i),  32'(bus.imem_addr), 32'(tbl[i].addr));
                chk($sformatf("row%0d wdata", i), bus.imem_wdata, tbl[i].wd);
            end
        end

        // junk bytes, then the basic frame with random idle gaps
        fr = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10};
        for (int i = 0; i < 16; i++) begin
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                step(0, 8'(($urandom & 32'hFF)), 0);
                chk("gap we", 32'(bus.imem_we), 32'd0);
            end
            if (i < 14)       step(1, fr[i], 0);
            else if (i == 14) step(1, 8'h00, 0);
            else              step(1, 8'h90, 0);
            chk($sformatf("gap byte%0d we", i), 32'(bus.imem_we), 32'((i == 10) || (i == 14)));
            if (i == 10) begin
                chk("gap addr0", 32'(bus.imem_addr), 32'(BASE));
                chk("gap data0", bus.imem_wdata, 32'h00000013);
            end
            if (i == 14) begin
                chk("gap addr1", 32'(bus.imem_addr), 32'(BASE + 1));
                chk("gap data1", bus.imem_wdata, 32'h00100093);
            end
        end
        chk("gap done", 32'(bus.done), 32'd1);
        chk("gap hold", 32'(bus.core_hold), 32'd0);
        chk("gap lw",   32'(bus.loaded_words), 32'd2);
        step(0, 8'h00, 1);

        // reset after two bytes of the first word
        fr2 = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 7; i++) step(1, fr2[i], 0);
        chk("pre-rst hold", 32'(bus.core_hold), 32'd1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset_values("midrst");
        @(posedge clk);
        #1 chk("midrst we held", 32'(bus.imem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        fr2 = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        for (int i = 0; i < 10; i++) begin
            step(1, fr2[i], 0);
            chk($sformatf("reload byte%0d we", i), 32'(bus.imem_we), 32'(i == 8));
            if (i == 8) begin
                chk("reload addr", 32'(bus.imem_addr), 32'(BASE));
                chk("reload data", bus.imem_wdata, 32'h44332211);
            end
        end
        chk("reload done", 32'(bus.done), 32'd1);
        chk("reload lw",   32'(bus.loaded_words), 32'd1);
        chk("reload hold", 32'(bus.core_hold), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
